// File: rtl/opcode_pkg.sv
// Shared opcode constants, fetch FSM states and the operand-length rule
// used by the instruction front end.
package opcode_pkg;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_JUD = 8'h03;
    localparam logic [7:0] OP_CUD = 8'h05;
    localparam logic [7:0] OP_JCD = 8'h08;
    localparam logic [7:0] OP_CCD = 8'h30;
    localparam logic [7:0] OP_MVI = 8'h58;
    localparam logic [7:0] OP_ADI = 8'h88;
    localparam logic [7:0] OP_ACI = 8'h98;
    localparam logic [7:0] OP_SUI = 8'hA8;
    localparam logic [7:0] OP_SBI = 8'hB8;
    localparam logic [7:0] OP_ANI = 8'hC8;
    localparam logic [7:0] OP_ORI = 8'hD8;
    localparam logic [7:0] OP_XRI = 8'hE8;

    typedef enum logic [1:0] {
        FETCH_OP = 2'd0,
        FETCH_OD = 2'd1,
        COMPLETE = 2'd2
    } fetch_state_t;

    // The immediate-operand ALU groups 88-8F .. E8-EF all have bit 7 and
    // bit 3 set; F8-FF is the only such group without an operand.
    function automatic logic needs_od(input logic [7:0] op);
        logic result;
        result = 1'b0;
        if (op == OP_JUD || op == OP_CUD)
            result = 1'b1;
        else if (op[7:3] == 5'b00001)
            result = 1'b1;
        else if (op[7:3] == 5'b00110)
            result = 1'b1;
        else if (op[7:3] == 5'b01011)
            result = 1'b1;
        else if (op[7] && op[3] && (op[6:4] != 3'b111))
            result = 1'b1;
        return result;
    endfunction

endpackage

// File: rtl/opcode_len_decode.sv
// Combinational instruction length decode: flags opcodes followed by an <od> byte.
module opcode_len_decode (
    input  logic [7:0] op,
    output logic       needs_od
);

    // Pure lookup through the shared package rule
    always_comb begin
        needs_od = opcode_pkg::needs_od(op);
    end

endmodule

// File: rtl/opcode_fetch_unit.sv
// Pipeline front end: fetches bytes from program memory, assembles 1- or 2-byte
// instructions and presents them to stage 2 with a bubble flag.
module opcode_fetch_unit
    import opcode_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_rd,
    input  logic [7:0]        imem_data,
    input  logic              imem_valid,
    input  logic              hold,
    input  logic              lpc,
    input  logic [ADDR_W-1:0] lpc_addr,
    output logic [7:0]        opcode,
    output logic [7:0]        od,
    output logic              od_valid,
    output logic              BB,
    output logic [ADDR_W-1:0] pc_issued
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] req_addr;
    logic [ADDR_W-1:0] stage_pc;
    logic [7:0]        stage_op;
    logic [7:0]        stage_od;
    logic              stage_odv;
    logic              outstanding;
    logic              stale;
    logic              fetch_en;
    logic              slot_full;
    logic              data_long;
    logic              issuing;
    logic              slot_free;
    logic              live_resp;
    logic              continue_ok;

    opcode_len_decode u_len (
        .op       (imem_data),
        .needs_od (data_long)
    );

    assign issuing   = slot_full & ~hold & ~lpc;
    assign slot_free = ~slot_full | issuing;
    assign live_resp = imem_valid & outstanding & ~stale;
    assign BB        = ~slot_full | hold | lpc;
    assign imem_addr = fetch_pc;

    // Decide whether the byte arriving now leaves room to launch the next request
    always_comb begin
        continue_ok = 1'b0;
        case (state)
            FETCH_OP: continue_ok = data_long | slot_free;
            FETCH_OD: continue_ok = slot_free;
            default:  continue_ok = 1'b0;
        endcase
    end

    // Request strobe: idle bus, or back-to-back when a live byte lands and has a home
    always_comb begin
        imem_rd = ~rst & ~lpc & fetch_en & (state != COMPLETE) &
                  (~outstanding | (live_resp & continue_ok));
    end

    // Fetch FSM, memory handshake tracking, staging register and output slot
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH_OP;
            fetch_pc    <= RESET_PC;
            req_addr    <= RESET_PC;
            stage_pc    <= RESET_PC;
            stage_op    <= OP_NOP;
            stage_od    <= 8'h00;
            stage_odv   <= 1'b0;
            outstanding <= 1'b0;
            stale       <= 1'b0;
            fetch_en    <= 1'b0;
            slot_full   <= 1'b0;
            opcode      <= OP_NOP;
            od          <= 8'h00;
            od_valid    <= 1'b0;
            pc_issued   <= RESET_PC;
        end else if (lpc) begin
            state       <= FETCH_OP;
            fetch_pc    <= lpc_addr;
            stage_op    <= OP_NOP;
            stage_od    <= 8'h00;
            stage_odv   <= 1'b0;
            slot_full   <= 1'b0;
            fetch_en    <= 1'b1;
            outstanding <= outstanding & ~imem_valid;
            stale       <= outstanding & ~imem_valid;
        end else begin
            fetch_en <= 1'b1;
            if (imem_rd) begin
                fetch_pc    <= fetch_pc + ADDR_W'(1);
                req_addr    <= fetch_pc;
                outstanding <= 1'b1;
            end else if (imem_valid) begin
                outstanding <= 1'b0;
            end
            if (imem_valid)
                stale <= 1'b0;
            if (issuing)
                slot_full <= 1'b0;
            case (state)
                FETCH_OP: begin
                    if (live_resp) begin
                        if (data_long) begin
                            stage_op <= imem_data;
                            stage_pc <= req_addr;
                            state    <= FETCH_OD;
                        end else if (slot_free) begin
                            opcode    <= imem_data;
                            od        <= 8'h00;
                            od_valid  <= 1'b0;
                            pc_issued <= req_addr;
                            slot_full <= 1'b1;
                        end else begin
                            stage_op  <= imem_data;
                            stage_od  <= 8'h00;
                            stage_odv <= 1'b0;
                            stage_pc  <= req_addr;
                            state     <= COMPLETE;
                        end
                    end
                end
                FETCH_OD: begin
                    if (live_resp) begin
                        if (slot_free) begin
                            opcode    <= stage_op;
                            od        <= imem_data;
                            od_valid  <= 1'b1;
                            pc_issued <= stage_pc;
                            slot_full <= 1'b1;
                            state     <= FETCH_OP;
                        end else begin
                            stage_od  <= imem_data;
                            stage_odv <= 1'b1;
                            state     <= COMPLETE;
                        end
                    end
                end
                COMPLETE: begin
                    if (slot_free) begin
                        opcode    <= stage_op;
                        od        <= stage_od;
                        od_valid  <= stage_odv;
                        pc_issued <= stage_pc;
                        slot_full <= 1'b1;
                        state     <= FETCH_OP;
                    end
                end
                default: state <= FETCH_OP;
            endcase
        end
    end

endmodule

// File: tb/tb_opcode_fetch_unit.sv
// Self-checking bench for opcode_fetch_unit with a configurable-latency memory model.
module tb_opcode_fetch_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] imem_addr;
    logic       imem_rd;
    logic [7:0] imem_data;
    logic       imem_valid;
    logic       hold;
    logic       lpc;
    logic [7:0] lpc_addr;
    logic [7:0] opcode;
    logic [7:0] od;
    logic       od_valid;
    logic       BB;
    logic [7:0] pc_issued;

    logic [7:0] ref_op;
    logic       ref_long;

    logic [7:0] mem [0:255];
    logic [1:0] lat;
    logic [1:0] cnt;
    logic [7:0] maddr;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic       hold;
        logic       rd;
        logic [7:0] addr;
        logic       bb;
        logic [7:0] op;
        logic [7:0] od;
        logic       odv;
        logic [7:0] pc;
    } vec_t;

    typedef struct {
        logic [7:0] op;
        logic       long_op;
    } len_t;

    vec_t vecs [15];
    len_t lens [24];

    always #5 clk = ~clk;

    opcode_fetch_unit #(
        .ADDR_W   (8),
        .RESET_PC (8'h00)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_addr  (imem_addr),
        .imem_rd    (imem_rd),
        .imem_data  (imem_data),
        .imem_valid (imem_valid),
        .hold       (hold),
        .lpc        (lpc),
        .lpc_addr   (lpc_addr),
        .opcode     (opcode),
        .od         (od),
        .od_valid   (od_valid),
        .BB         (BB),
        .pc_issued  (pc_issued)
    );

    opcode_len_decode u_ref (
        .op       (ref_op),
        .needs_od (ref_long)
    );

    // Program memory: answers each request after 'lat' cycles, cleared by the shared reset
    always @(posedge clk) begin
        if (rst) begin
            cnt   <= 2'd0;
            maddr <= 8'h00;
        end else if (imem_rd) begin
            cnt   <= lat;
            maddr <= imem_addr;
        end else if (cnt != 2'd0) begin
            cnt <= cnt - 2'd1;
        end
    end

    assign imem_valid = (cnt == 2'd1);
    assign imem_data  = mem[maddr];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic h, input logic l, input logic [7:0] la);
        @(negedge clk);
        rst      = r;
        hold     = h;
        lpc      = l;
        lpc_addr = la;
        #1;
    endtask

    task automatic checkAll(input string tag, input logic rd, input logic [7:0] addr,
                            input logic bb, input logic [7:0] op, input logic [7:0] odx,
                            input logic odv, input logic [7:0] pc);
        checkOutput({tag, " imem_rd"}, imem_rd, rd);
        checkOutput({tag, " imem_addr"}, imem_addr, addr);
        checkOutput({tag, " BB"}, BB, bb);
        checkOutput({tag, " opcode"}, opcode, op);
        checkOutput({tag, " od"}, od, odx);
        checkOutput({tag, " od_valid"}, od_valid, odv);
        checkOutput({tag, " pc_issued"}, pc_issued, pc);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    // Idle until the next issue (BB=0), giving up after a fixed cycle budget
    task automatic waitIssue(input string name);
        logic found;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
            if (BB == 1'b0)
                found = 1'b1;
        end
        checkOutput({name, " issue seen"}, found, 1'b1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic       seen_mvi;
        logic [7:0] mvi_od;
        logic       found;

        rst = 1'b1; hold = 1'b0; lpc = 1'b0; lpc_addr = 8'h00; ref_op = 8'h00; lat = 2'd1;
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        mem[8'h00] = 8'h01; mem[8'h01] = 8'h02; mem[8'h02] = 8'h00; mem[8'h03] = 8'h58;
        mem[8'h04] = 8'h3C; mem[8'h05] = 8'h88; mem[8'h06] = 8'h05; mem[8'h07] = 8'h04;
        mem[8'h08] = 8'h03; mem[8'h09] = 8'h11; mem[8'h20] = 8'h03; mem[8'h21] = 8'h11;
        mem[8'h40] = 8'h07; mem[8'h41] = 8'h00; mem[8'hFF] = 8'h04;

        //              hold  rd    addr   bb    op     od     odv   pc
        vecs[0]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00};
        vecs[1]  = '{1'b0, 1'b1, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00};
        vecs[2]  = '{1'b0, 1'b1, 8'h01, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00};
        vecs[3]  = '{1'b0, 1'b1, 8'h02, 1'b0, 8'h01, 8'h00, 1'b0, 8'h00};
        vecs[4]  = '{1'b0, 1'b1, 8'h03, 1'b0, 8'h02, 8'h00, 1'b0, 8'h01};
        vecs[5]  = '{1'b0, 1'b1, 8'h04, 1'b0, 8'h00, 8'h00, 1'b0, 8'h02};
        vecs[6]  = '{1'b0, 1'b1, 8'h05, 1'b1, 8'h00, 8'h00, 1'b0, 8'h02};
        vecs[7]  = '{1'b0, 1'b1, 8'h06, 1'b0, 8'h58, 8'h3C, 1'b1, 8'h03};
        vecs[8]  = '{1'b0, 1'b1, 8'h07, 1'b1, 8'h58, 8'h3C, 1'b1, 8'h03};
        vecs[9]  = '{1'b1, 1'b0, 8'h08, 1'b1, 8'h88, 8'h05, 1'b1, 8'h05};
        vecs[10] = '{1'b1, 1'b0, 8'h08, 1'b1, 8'h88, 8'h05, 1'b1, 8'h05};
        vecs[11] = '{1'b1, 1'b0, 8'h08, 1'b1, 8'h88, 8'h05, 1'b1, 8'h05};
        vecs[12] = '{1'b0, 1'b0, 8'h08, 1'b0, 8'h88, 8'h05, 1'b1, 8'h05};
        vecs[13] = '{1'b0, 1'b1, 8'h08, 1'b0, 8'h04, 8'h00, 1'b0, 8'h07};
        vecs[14] = '{1'b0, 1'b1, 8'h09, 1'b1, 8'h04, 8'h00, 1'b0, 8'h07};

        lens[0]  = '{8'h00, 1'b0}; lens[1]  = '{8'h03, 1'b1}; lens[2]  = '{8'h04, 1'b0};
        lens[3]  = '{8'h05, 1'b1}; lens[4]  = '{8'h07, 1'b0}; lens[5]  = '{8'h08, 1'b1};
        lens[6]  = '{8'h0F, 1'b1}; lens[7]  = '{8'h10, 1'b0}; lens[8]  = '{8'h2F, 1'b0};
        lens[9]  = '{8'h30, 1'b1}; lens[10] = '{8'h37, 1'b1}; lens[11] = '{8'h38, 1'b0};
        lens[12] = '{8'h58, 1'b1}; lens[13] = '{8'h5F, 1'b1}; lens[14] = '{8'h60, 1'b0};
        lens[15] = '{8'h88, 1'b1}; lens[16] = '{8'h90, 1'b0}; lens[17] = '{8'h9F, 1'b1};
        lens[18] = '{8'hA8, 1'b1}; lens[19] = '{8'hBF, 1'b1}; lens[20] = '{8'hC8, 1'b1};
        lens[21] = '{8'hD8, 1'b1}; lens[22] = '{8'hEF, 1'b1}; lens[23] = '{8'hF8, 1'b0};

        for (int i = 0; i < 24; i++) begin
            ref_op = lens[i].op;
            #1;
            checkOutput($sformatf("len %02h", lens[i].op), ref_long, lens[i].long_op);
        end

        // 1-byte stream, MVI 58/3C, then hold on ADI 88/05 with 04 waiting behind it
        $display("[TB] table: 1-byte stream, MVI, hold");
        lat = 2'd1;
        doReset();
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1'b0, vecs[i].hold, 1'b0, 8'h00);
            checkAll($sformatf("vec%0d", i), vecs[i].rd, vecs[i].addr, vecs[i].bb,
                     vecs[i].op, vecs[i].od, vecs[i].odv, vecs[i].pc);
        end

        // Redirect while the response to byte 03 at 20 is still in flight
        $display("[TB] lpc with outstanding response");
        lat = 2'd2;
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h20);
        checkOutput("lpc0 imem_rd", imem_rd, 1'b0);
        checkOutput("lpc0 BB", BB, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("lpc1 imem_rd", imem_rd, 1'b1);
        checkOutput("lpc1 imem_addr", imem_addr, 8'h20);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h40);
        checkOutput("lpc2 imem_rd", imem_rd, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("lpc3 stale imem_rd", imem_rd, 1'b0);
        checkOutput("lpc3 imem_addr", imem_addr, 8'h40);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("lpc4 imem_rd", imem_rd, 1'b1);
        checkOutput("lpc4 imem_addr", imem_addr, 8'h40);
        waitIssue("lpc");
        checkOutput("lpc opcode", opcode, 8'h07);
        checkOutput("lpc pc_issued", pc_issued, 8'h40);
        checkOutput("lpc od_valid", od_valid, 1'b0);

        // Fetch PC wrap from FF to 00
        $display("[TB] pc wrap");
        lat = 2'd1;
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hFF);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("wrap1 imem_rd", imem_rd, 1'b1);
        checkOutput("wrap1 imem_addr", imem_addr, 8'hFF);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("wrap2 imem_rd", imem_rd, 1'b1);
        checkOutput("wrap2 imem_addr", imem_addr, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("wrap3 BB", BB, 1'b0);
        checkOutput("wrap3 opcode", opcode, 8'h04);
        checkOutput("wrap3 pc_issued", pc_issued, 8'hFF);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("wrap4 BB", BB, 1'b0);
        checkOutput("wrap4 opcode", opcode, 8'h01);
        checkOutput("wrap4 pc_issued", pc_issued, 8'h00);

        // Reset while waiting for the operand of 88 with a 2-cycle memory
        $display("[TB] reset in FETCH_OD");
        lat = 2'd2;
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h03);
        seen_mvi = 1'b0;
        mvi_od   = 8'h00;
        found    = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
            if (BB == 1'b0 && opcode == 8'h58 && od_valid == 1'b1) begin
                seen_mvi = 1'b1;
                mvi_od   = od;
            end
            if (imem_rd == 1'b1 && imem_addr == 8'h06)
                found = 1'b1;
        end
        checkOutput("rst6 od fetch seen", found, 1'b1);
        checkOutput("rst6 MVI issued", seen_mvi, 1'b1);
        checkOutput("rst6 MVI od", mvi_od, 8'h3C);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        checkAll("rst6 after", 1'b0, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("rst6 restart imem_rd", imem_rd, 1'b1);
        checkOutput("rst6 restart imem_addr", imem_addr, 8'h00);
        waitIssue("rst6");
        checkOutput("rst6 opcode", opcode, 8'h01);
        checkOutput("rst6 pc_issued", pc_issued, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
